// File: rtl/decode_queue.sv
// decode_queue: RV32I decoder (+ M ops when DECODE_M_EXT_EN is defined) feeding a DEPTH-entry queue of decoded ops.
// Latency: 1 cycle from an accepted instruction to its presentation at the head.
// Backpressure: o_ready drops when the queue is full; the head entry holds while o_valid && !i_ready.

// dq_fifo: generic register-based FIFO with synchronous flush; storage cleared by reset.
// Latency: 1 cycle from push to head; head_dat is read straight from storage.
// Backpressure: a push while full or a pop while empty is ignored.
module dq_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic         push_vld,
    input  logic [W-1:0] push_dat,
    input  logic         pop_vld,
    output logic [W-1:0] head_dat,
    output logic         full,
    output logic         empty
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          push;
    logic          pop;

    assign full     = (count == FULL_CNT);
    assign empty    = (count == '0);
    assign push     = push_vld && !full;
    assign pop      = pop_vld && !empty;
    assign head_dat = mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_dat;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

module decode_queue #(
    parameter int PC_W  = 32,
    parameter int DEPTH = 2
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_flush,
    input  logic            i_valid,
    output logic            o_ready,
    input  logic [31:0]     i_instr,
    input  logic [PC_W-1:0] i_pc,
    output logic            o_valid,
    input  logic            i_ready,
    output logic [PC_W-1:0] o_pc,
    output logic [4:0]      o_rs1_addr,
    output logic [4:0]      o_rs2_addr,
    output logic [4:0]      o_rd_addr,
    output logic [31:0]     o_imm,
    output logic            o_rd_wren,
    output logic            o_mem_wren,
    output logic            o_is_load,
    output logic            o_op_a_sel,
    output logic            o_op_b_sel,
    output logic            o_branch,
    output logic            o_jump,
    output logic [4:0]      o_alu_op,
    output logic [2:0]      o_br_op,
    output logic [3:0]      o_ld_op,
    output logic            o_illegal,
    output logic [15:0]     o_illegal_cnt
);
    typedef struct packed {
        logic [PC_W-1:0] pc;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic [31:0]     imm;
        logic            rd_wren;
        logic            mem_wren;
        logic            is_load;
        logic            op_a_sel;
        logic            op_b_sel;
        logic            branch;
        logic            jump;
        logic [4:0]      alu_op;
        logic [2:0]      br_op;
        logic [3:0]      ld_op;
        logic            illegal;
    } meta_t;

    meta_t       dec_dat;
    meta_t       head_dat;
    logic        illegal;
    logic        fifo_full;
    logic        fifo_empty;
    logic        push_acc;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;

    assign opcode = i_instr[6:0];
    assign funct3 = i_instr[14:12];
    assign funct7 = i_instr[31:25];

    // alt selects sub/sra for the funct3 codes that have a second form.
    function automatic logic [4:0] alu_of(input logic [2:0] f3, input logic alt);
        case (f3)
            3'b000:  return alt ? 5'd1 : 5'd0;
            3'b001:  return 5'd7;
            3'b010:  return 5'd2;
            3'b011:  return 5'd3;
            3'b100:  return 5'd4;
            3'b101:  return alt ? 5'd9 : 5'd8;
            3'b110:  return 5'd5;
            default: return 5'd6;
        endcase
    endfunction

    always_comb begin
        dec_dat     = '0;
        illegal     = 1'b0;
        dec_dat.pc  = i_pc;
        dec_dat.rs1 = i_instr[19:15];
        dec_dat.rs2 = i_instr[24:20];
        dec_dat.rd  = i_instr[11:7];
        case (opcode)
            7'b0110111: begin // LUI: operand A forced to x0
                dec_dat.rs1      = '0;
                dec_dat.rd_wren  = 1'b1;
                dec_dat.op_b_sel = 1'b1;
                dec_dat.imm      = {i_instr[31:12], 12'b0};
            end
            7'b0010111: begin
                dec_dat.rd_wren  = 1'b1;
                dec_dat.op_a_sel = 1'b1;
                dec_dat.op_b_sel = 1'b1;
                dec_dat.imm      = {i_instr[31:12], 12'b0};
            end
            7'b1101111: begin
                dec_dat.rd_wren  = 1'b1;
                dec_dat.jump     = 1'b1;
                dec_dat.op_a_sel = 1'b1;
                dec_dat.op_b_sel = 1'b1;
                dec_dat.br_op    = 3'd6;
                dec_dat.imm      = {{11{i_instr[31]}}, i_instr[31], i_instr[19:12],
                                    i_instr[20], i_instr[30:21], 1'b0};
            end
            7'b1100111: begin
                dec_dat.rd_wren  = 1'b1;
                dec_dat.jump     = 1'b1;
                dec_dat.op_b_sel = 1'b1;
                dec_dat.br_op    = 3'd7;
                dec_dat.imm      = {{20{i_instr[31]}}, i_instr[31:20]};
            end
            7'b1100011: begin
                dec_dat.branch = 1'b1;
                dec_dat.imm    = {{19{i_instr[31]}}, i_instr[31], i_instr[7],
                                  i_instr[30:25], i_instr[11:8], 1'b0};
                case (funct3)
                    3'b000:  dec_dat.br_op = 3'd0;
                    3'b001:  dec_dat.br_op = 3'd1;
                    3'b100:  dec_dat.br_op = 3'd2;
                    3'b101:  dec_dat.br_op = 3'd3;
                    3'b110:  dec_dat.br_op = 3'd4;
                    3'b111:  dec_dat.br_op = 3'd5;
                    default: illegal = 1'b1;
                endcase
            end
            7'b0000011: begin // ld_op = {signed, byte-lane mask}
                dec_dat.rd_wren  = 1'b1;
                dec_dat.is_load  = 1'b1;
                dec_dat.op_b_sel = 1'b1;
                dec_dat.imm      = {{20{i_instr[31]}}, i_instr[31:20]};
                case (funct3)
                    3'b000:  dec_dat.ld_op = 4'b1001;
                    3'b001:  dec_dat.ld_op = 4'b1011;
                    3'b010:  dec_dat.ld_op = 4'b1111;
                    3'b100:  dec_dat.ld_op = 4'b0001;
                    3'b101:  dec_dat.ld_op = 4'b0011;
                    default: illegal = 1'b1;
                endcase
            end
            7'b0100011: begin
                dec_dat.mem_wren = 1'b1;
                dec_dat.op_b_sel = 1'b1;
                dec_dat.imm      = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
                if (funct3 >= 3'b011) illegal = 1'b1;
            end
            7'b0010011: begin
                dec_dat.rd_wren  = 1'b1;
                dec_dat.op_b_sel = 1'b1;
                dec_dat.imm      = {{20{i_instr[31]}}, i_instr[31:20]};
                dec_dat.alu_op   = alu_of(funct3, 1'b0);
                if (funct3 == 3'b001 || funct3 == 3'b101) begin
                    dec_dat.imm = {27'b0, i_instr[24:20]};
                    if (funct7 == 7'b0100000 && funct3 == 3'b101) dec_dat.alu_op = 5'd9;
                    else if (funct7 != 7'b0000000)                illegal = 1'b1;
                end
            end
            7'b0110011: begin
                dec_dat.rd_wren = 1'b1;
                if (funct7 == 7'b0000000)
                    dec_dat.alu_op = alu_of(funct3, 1'b0);
                else if (funct7 == 7'b0100000 && (funct3 == 3'b000 || funct3 == 3'b101))
                    dec_dat.alu_op = alu_of(funct3, 1'b1);
`ifdef DECODE_M_EXT_EN
                else if (funct7 == 7'b0000001)
                    dec_dat.alu_op = 5'd10 + {2'b00, funct3};
`endif
                else
                    illegal = 1'b1;
            end
            default: illegal = 1'b1;
        endcase
        if (illegal) begin
            dec_dat.rd_wren  = 1'b0;
            dec_dat.mem_wren = 1'b0;
            dec_dat.branch   = 1'b0;
            dec_dat.jump     = 1'b0;
            dec_dat.is_load  = 1'b0;
            dec_dat.imm      = '0;
        end
        dec_dat.illegal = illegal;
    end

    dq_fifo #(.W($bits(meta_t)), .DEPTH(DEPTH)) u_fifo (
        .clk      (i_clk),
        .rst_n    (i_rst_n),
        .flush    (i_flush),
        .push_vld (i_valid),
        .push_dat (dec_dat),
        .pop_vld  (i_ready),
        .head_dat (head_dat),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    assign o_ready  = !fifo_full;
    assign o_valid  = !fifo_empty;
    assign push_acc = i_valid && o_ready && !i_flush;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            o_illegal_cnt <= '0;
        else if (push_acc && dec_dat.illegal && o_illegal_cnt != 16'hFFFF)
            o_illegal_cnt <= o_illegal_cnt + 16'd1;
    end

    assign o_pc       = head_dat.pc;
    assign o_rs1_addr = head_dat.rs1;
    assign o_rs2_addr = head_dat.rs2;
    assign o_rd_addr  = head_dat.rd;
    assign o_imm      = head_dat.imm;
    assign o_rd_wren  = head_dat.rd_wren;
    assign o_mem_wren = head_dat.mem_wren;
    assign o_is_load  = head_dat.is_load;
    assign o_op_a_sel = head_dat.op_a_sel;
    assign o_op_b_sel = head_dat.op_b_sel;
    assign o_branch   = head_dat.branch;
    assign o_jump     = head_dat.jump;
    assign o_alu_op   = head_dat.alu_op;
    assign o_br_op    = head_dat.br_op;
    assign o_ld_op    = head_dat.ld_op;
    assign o_illegal  = head_dat.illegal;
endmodule

// File: tb/tb_decode_queue.sv
// Directed bench for decode_queue (DEPTH=2, PC_W=32); expectations are hand-computed encodings.
module tb_decode_queue;
    logic        i_clk = 1'b0;
    logic        i_rst_n;
    logic        i_flush;
    logic        i_valid;
    logic        o_ready;
    logic [31:0] i_instr;
    logic [31:0] i_pc;
    logic        o_valid;
    logic        i_ready;
    logic [31:0] o_pc;
    logic [4:0]  o_rs1_addr, o_rs2_addr, o_rd_addr;
    logic [31:0] o_imm;
    logic        o_rd_wren, o_mem_wren, o_is_load, o_op_a_sel, o_op_b_sel, o_branch, o_jump;
    logic [4:0]  o_alu_op;
    logic [2:0]  o_br_op;
    logic [3:0]  o_ld_op;
    logic        o_illegal;
    logic [15:0] o_illegal_cnt;

    int n_cmp = 0;
    int n_bad = 0;
    logic [15:0] exp_cnt;

    decode_queue #(.PC_W(32), .DEPTH(2)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_flush(i_flush),
        .i_valid(i_valid), .o_ready(o_ready), .i_instr(i_instr), .i_pc(i_pc),
        .o_valid(o_valid), .i_ready(i_ready), .o_pc(o_pc),
        .o_rs1_addr(o_rs1_addr), .o_rs2_addr(o_rs2_addr), .o_rd_addr(o_rd_addr),
        .o_imm(o_imm), .o_rd_wren(o_rd_wren), .o_mem_wren(o_mem_wren),
        .o_is_load(o_is_load), .o_op_a_sel(o_op_a_sel), .o_op_b_sel(o_op_b_sel),
        .o_branch(o_branch), .o_jump(o_jump), .o_alu_op(o_alu_op), .o_br_op(o_br_op),
        .o_ld_op(o_ld_op), .o_illegal(o_illegal), .o_illegal_cnt(o_illegal_cnt)
    );

    always #5 i_clk = ~i_clk;

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [31:0] instr, input logic [31:0] pc);
        i_valid = 1'b1;
        i_instr = instr;
        i_pc    = pc;
        tick();
        i_valid = 1'b0;
    endtask

    initial begin
        i_rst_n = 1'b0; i_flush = 1'b0; i_valid = 1'b0; i_ready = 1'b0;
        i_instr = '0;   i_pc = '0;
        #12;
        chk("rst_valid", o_valid, 0);
        chk("rst_ready", o_ready, 1);
        chk("rst_cnt", o_illegal_cnt, 0);
        chk("rst_imm", o_imm, 0);
        chk("rst_rd", o_rd_addr, 0);
        i_rst_n = 1'b1;
        tick();

        // addi x1,x0,5
        push(32'h00500093, 32'h100);
        chk("addi_valid", o_valid, 1);
        chk("addi_rd", o_rd_addr, 1);
        chk("addi_imm", o_imm, 5);
        chk("addi_alu", o_alu_op, 0);
        chk("addi_bsel", o_op_b_sel, 1);
        chk("addi_wren", o_rd_wren, 1);
        chk("addi_pc", o_pc, 32'h100);
        chk("addi_ready", o_ready, 1);
        i_ready = 1'b1;
        tick();
        chk("addi_drained", o_valid, 0);
        i_ready = 1'b0;

        // fill with sub x3,x1,x2 and lw x5,8(x2); third push must be dropped
        push(32'h402081B3, 32'h200);
        chk("fill1_ready", o_ready, 1);
        push(32'h00812283, 32'h204);
        chk("full_ready", o_ready, 0);
        chk("full_head_alu", o_alu_op, 1);
        chk("full_head_pc", o_pc, 32'h200);
        push(32'h00100093, 32'h208);
        chk("drop_ready", o_ready, 0);
        chk("drop_head_rd", o_rd_addr, 3);
        chk("drop_head_bsel", o_op_b_sel, 0);
        i_ready = 1'b1;
        tick();
        chk("lw_pc", o_pc, 32'h204);
        chk("lw_load", o_is_load, 1);
        chk("lw_ldop", o_ld_op, 4'b1111);
        chk("lw_imm", o_imm, 8);
        chk("lw_rd", o_rd_addr, 5);
        chk("lw_rs1", o_rs1_addr, 2);
        chk("lw_ready", o_ready, 1);
        tick();
        chk("drain_empty", o_valid, 0);
        i_ready = 1'b0;

        // sw x2,12(x1), then simultaneous push bne x1,x2,-4 and pop
        push(32'h0020A623, 32'h300);
        chk("sw_memw", o_mem_wren, 1);
        chk("sw_imm", o_imm, 12);
        chk("sw_wren", o_rd_wren, 0);
        chk("sw_rs2", o_rs2_addr, 2);
        i_ready = 1'b1;
        push(32'hFE209EE3, 32'h304);
        i_ready = 1'b0;
        chk("pp_valid", o_valid, 1);
        chk("pp_ready", o_ready, 1);
        chk("bne_branch", o_branch, 1);
        chk("bne_brop", o_br_op, 1);
        chk("bne_imm", o_imm, 32'hFFFFFFFC);
        chk("bne_pc", o_pc, 32'h304);

        // fill, then flush with push and pop on the same edge
        push(32'h010000EF, 32'h308);
        chk("fl_full", o_ready, 0);
        chk("fl_hold_brop", o_br_op, 1);
        i_valid = 1'b1; i_instr = 32'hFFFFFFFF; i_ready = 1'b1; i_flush = 1'b1;
        tick();
        chk("fl_valid", o_valid, 0);
        chk("fl_ready", o_ready, 1);
        i_ready = 1'b0;
        tick();
        chk("fl_push_dropped", o_valid, 0);
        chk("fl_cnt", o_illegal_cnt, 0);
        i_flush = 1'b0; i_valid = 1'b0;

        // jal x1,16
        push(32'h010000EF, 32'h400);
        chk("jal_jump", o_jump, 1);
        chk("jal_brop", o_br_op, 6);
        chk("jal_imm", o_imm, 16);
        chk("jal_asel", o_op_a_sel, 1);
        chk("jal_wren", o_rd_wren, 1);
        i_ready = 1'b1; tick(); i_ready = 1'b0;

        // illegal encodings
        exp_cnt = 16'd0;
        push(32'hFFFFFFFF, 32'h500);
        exp_cnt = exp_cnt + 16'd1;
        chk("ill_flag", o_illegal, 1);
        chk("ill_wren", o_rd_wren, 0);
        chk("ill_imm", o_imm, 0);
        chk("ill_cnt", o_illegal_cnt, exp_cnt);
        i_ready = 1'b1; tick(); i_ready = 1'b0;

        push(32'h02208033, 32'h504);
`ifdef DECODE_M_EXT_EN
        chk("mul_flag", o_illegal, 0);
        chk("mul_alu", o_alu_op, 10);
`else
        exp_cnt = exp_cnt + 16'd1;
        chk("mul_flag", o_illegal, 1);
        chk("mul_wren", o_rd_wren, 0);
`endif
        chk("mul_cnt", o_illegal_cnt, exp_cnt);
        i_ready = 1'b1; tick(); i_ready = 1'b0;

        push(32'h00013003, 32'h508);
        exp_cnt = exp_cnt + 16'd1;
        chk("ld011_flag", o_illegal, 1);
        chk("ld011_load", o_is_load, 0);
        chk("ld011_cnt", o_illegal_cnt, exp_cnt);
        i_ready = 1'b1; tick();

        // stream illegal words until the counter saturates
        i_valid = 1'b1; i_instr = 32'hFFFFFFFF;
        for (int k = 0; k < 65540; k++) tick();
        i_valid = 1'b0;
        chk("sat_cnt", o_illegal_cnt, 16'hFFFF);
        tick();
        chk("sat_drained", o_valid, 0);
        i_ready = 1'b0;

        // async reset with two entries queued
        push(32'h00500093, 32'h600);
        push(32'h00500093, 32'h604);
        chk("pre_rst_full", o_ready, 0);
        #2;
        i_rst_n = 1'b0;
        #1;
        chk("arst_valid", o_valid, 0);
        chk("arst_cnt", o_illegal_cnt, 0);
        chk("arst_ready", o_ready, 1);
        chk("arst_pc", o_pc, 0);
        #2;
        i_rst_n = 1'b1;
        tick();
        chk("post_rst_valid", o_valid, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/decode_queue.md
DECODE_QUEUE -- requirements
Module: decode_queue

Interface
REQ-001 SHALL have parameter PC_W, default 32, PC width carried with each instruction.
REQ-002 SHALL have parameter DEPTH, default 2, queue entries (power of two, >=2).
REQ-003 SHALL have port i_clk  input  1  sole clock, all state on rising edge.
REQ-004 SHALL have port i_rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port i_flush  input  1  synchronous queue discard.
REQ-006 SHALL have port i_valid / o_ready  input / output  1 / 1  upstream handshake.
REQ-007 SHALL have port i_instr  input  32  RV32 instruction word.
REQ-008 SHALL have port i_pc  input  PC_W  instruction address.
REQ-009 SHALL have port o_valid / i_ready  output / input  1 / 1  downstream handshake.
REQ-010 SHALL have port o_pc  output  PC_W  head-entry PC.
REQ-011 SHALL have ports o_rs1_addr, o_rs2_addr, o_rd_addr  output  5 each  register addresses.
REQ-012 SHALL have port o_imm  output  32  sign-extended immediate (I/S/B/J/U formats).
REQ-013 SHALL have ports o_rd_wren, o_mem_wren, o_is_load, o_op_a_sel, o_op_b_sel, o_branch, o_jump  output  1 each  datapath controls.
REQ-014 SHALL have ports o_alu_op 5, o_br_op 3, o_ld_op 4  output  operation codes.
REQ-015 SHALL have port o_illegal  output  1  head entry is an unsupported encoding.
REQ-016 SHALL have port o_illegal_cnt  output  16  saturating count of illegal instructions accepted.

Function
REQ-017 SHALL decode i_instr combinationally at input and store decoded fields plus i_pc into a DEPTH-entry FIFO; all outputs SHALL be driven from the head entry registers.
REQ-018 SHALL use alu_op: add 0, sub 1, slt 2, sltu 3, xor 4, or 5, and 6, sll 7, srl 8, sra 9; LUI/AUIPC/load/store/branch/JAL/JALR 0; br_op BEQ0 BNE1 BLT2 BGE3 BLTU4 BGEU5 JAL6 JALR7; ld_op {signed, size mask 001/011/111}.
REQ-019 SHALL accept on edge when i_valid && o_ready; o_ready = (count < DEPTH), no full-queue bypass.
REQ-020 SHALL pop on edge when o_valid && i_ready; o_valid = (count > 0).
REQ-021 SHALL take latency 1: instruction accepted at edge N into empty queue is presented with o_valid=1 after edge N.
REQ-022 SHALL perform simultaneous push and pop in one edge with count unchanged; pointers wrap modulo DEPTH.
REQ-023 SHALL, on i_flush, empty queue next edge (count=0, pointers 0) regardless of simultaneous push/pop; the push is discarded and o_illegal_cnt not incremented.
REQ-024 SHALL flag illegal: unknown opcode, branch funct3 010/011, load funct3 011/110/111, store funct3 >=011, OP funct7 not 0000000/0100000 (0100000 only with funct3 000/101), OP-IMM shift funct7 invalid.
REQ-025 SHALL force illegal entries to rd_wren=0, mem_wren=0, branch=0, jump=0, is_load=0, imm=0.
REQ-026 SHALL increment o_illegal_cnt per accepted illegal instruction, saturating at 16'hFFFF.
REQ-027 SHALL hold head outputs stable while o_valid && !i_ready.

Reset
REQ-028 SHALL, while i_rst_n=0, clear count, pointers, o_illegal_cnt and all head outputs to 0 (o_valid=0, o_ready=1 after release); reset mid-transfer discards all entries.

Configuration
REQ-029 SHALL, with DECODE_M_EXT_EN defined, decode OP funct7 0000001 as mul 10, mulh 11, mulhsu 12, mulhu 13, div 14, divu 15, rem 16, remu 17; without it such instructions SHALL be illegal and o_alu_op[4] constant 0.

Verification
REQ-030 SHALL cover: push 0x00500093 (addi x1,x0,5) into empty queue -> next cycle o_valid=1, rd=1, imm=5, alu_op=0, op_b_sel=1.
REQ-031 SHALL cover: i_ready=0, push DEPTH instrs -> o_ready=0 after edge DEPTH; extra i_valid ignored; drain returns all in order.
REQ-032 SHALL cover: full queue, push/pop and i_flush same edge -> count=0, o_valid=0 next cycle.
REQ-033 SHALL cover: 0xFFFFFFFF accepted -> o_illegal=1, rd_wren=0, o_illegal_cnt=1; 0x02208033 (mul) -> alu_op 10 with macro, illegal without.
REQ-034 SHALL cover: i_rst_n low with 2 entries queued -> o_valid=0, o_illegal_cnt=0 immediately, without clock edge.
